// File: rtl/hazard_forward_ctrl_pkg.sv
// Shared types for the EX-stage forwarding / load-use / flush controller.
package hazard_forward_ctrl_pkg;

   localparam int unsigned RD_MAX_W = 8;

   typedef enum logic [1:0] {
      FWD_REG = 2'd0,
      FWD_ALU = 2'd1,
      FWD_WB  = 2'd2
   } forward_mux_code_e;

   typedef logic [1:0] hazard_state_t;
   localparam hazard_state_t RUN        = 2'd0;
   localparam hazard_state_t LOAD_STALL = 2'd1;
   localparam hazard_state_t FLUSH      = 2'd2;

   // Register addresses are zero-extended to RD_MAX_W inside the shadow pipeline.
   typedef struct packed {
      logic                valid;
      logic [RD_MAX_W-1:0] rd;
      logic                reg_write;
      logic                is_load;
   } shadow_slot_t;

   // A valid, writing producer of a non-x0 register that equals rs.
   function automatic logic slot_match(shadow_slot_t s, logic [RD_MAX_W-1:0] rs);
      return s.valid && s.reg_write && (s.rd != '0) && (s.rd == rs);
   endfunction

endpackage

// File: rtl/hazard_forward_ctrl_if.sv
// Decode/EX-side signal bundle of the hazard controller.
interface hazard_forward_ctrl_if #(
   parameter int unsigned REG_ADDR_W = 5,
   parameter int unsigned CNT_W      = 32
);
   import hazard_forward_ctrl_pkg::*;

   logic                  id_valid_ip;
   logic [REG_ADDR_W-1:0] id_rs1_addr_ip;
   logic                  id_rs1_used_ip;
   logic [REG_ADDR_W-1:0] id_rs2_addr_ip;
   logic                  id_rs2_used_ip;
   logic [REG_ADDR_W-1:0] id_rd_addr_ip;
   logic                  id_reg_write_ip;
   logic                  id_is_load_ip;
   logic                  ex_redirect_ip;
   forward_mux_code_e     fa_mux_op;
   forward_mux_code_e     fb_mux_op;
   logic                  stall_if_op;
   logic                  stall_id_op;
   logic                  bubble_ex_op;
   logic                  flush_if_op;
   logic                  flush_id_op;
   logic [CNT_W-1:0]      stall_count_op;
   logic [CNT_W-1:0]      flush_count_op;

   modport master (
      output id_valid_ip, id_rs1_addr_ip, id_rs1_used_ip, id_rs2_addr_ip, id_rs2_used_ip,
             id_rd_addr_ip, id_reg_write_ip, id_is_load_ip, ex_redirect_ip,
      input  fa_mux_op, fb_mux_op, stall_if_op, stall_id_op, bubble_ex_op,
             flush_if_op, flush_id_op, stall_count_op, flush_count_op
   );

   modport slave (
      input  id_valid_ip, id_rs1_addr_ip, id_rs1_used_ip, id_rs2_addr_ip, id_rs2_used_ip,
             id_rd_addr_ip, id_reg_write_ip, id_is_load_ip, ex_redirect_ip,
      output fa_mux_op, fb_mux_op, stall_if_op, stall_id_op, bubble_ex_op,
             flush_if_op, flush_id_op, stall_count_op, flush_count_op
   );

endinterface

// File: rtl/hazard_forward_ctrl_sat_counter.sv
// Saturating event counter for hazard performance statistics.
module hazard_sat_counter #(
   parameter int unsigned CNT_W = 32
) (
   input  logic             clock,
   input  logic             reset,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Forward-select, load-use stall and redirect-flush controller beside decode,
// tracking in-flight producers in a shadow ID/EX -> EX/MEM pipeline.
module hazard_forward_ctrl
   import hazard_forward_ctrl_pkg::*;
#(
   parameter int unsigned REG_ADDR_W  = 5,
   parameter int unsigned FLUSH_DEPTH = 2,
   parameter int unsigned CNT_W       = 32
) (
   input logic                  clock,
   input logic                  reset,
   hazard_forward_ctrl_if.slave bus
);

   localparam int unsigned FC_W = (FLUSH_DEPTH > 1) ? $clog2(FLUSH_DEPTH) : 1;

   hazard_state_t     state_q, state_d;
   logic [FC_W-1:0]   fcnt_q, fcnt_d;
   shadow_slot_t      ex_q, ex_d, mem_q;
   forward_mux_code_e fa_q, fa_d, fb_q, fb_d;

   logic [REG_ADDR_W-1:0] rs1_a, rs2_a, rd_a;
   logic [RD_MAX_W-1:0]   rs1, rs2;
   logic                  redirect_c, flush_c, ld_hit, load_use_c;
   logic [CNT_W-1:0]      stall_cnt, flush_cnt;

   // Youngest non-load producer forwards from ALU; older producer from writeback.
   function automatic forward_mux_code_e fwd_sel(logic used, logic [RD_MAX_W-1:0] rs,
                                                 shadow_slot_t ex_s, shadow_slot_t mem_s);
      if (used && slot_match(ex_s, rs) && !ex_s.is_load) return FWD_ALU;
      if (used && slot_match(mem_s, rs))                 return FWD_WB;
      return FWD_REG;
   endfunction

   assign rs1_a = bus.id_rs1_addr_ip;
   assign rs2_a = bus.id_rs2_addr_ip;
   assign rd_a  = bus.id_rd_addr_ip;

   always_comb begin
      rs1        = RD_MAX_W'(rs1_a);
      rs2        = RD_MAX_W'(rs2_a);
      redirect_c = !reset && bus.ex_redirect_ip && (state_q != FLUSH);
      flush_c    = !reset && (redirect_c || (state_q == FLUSH));
      ld_hit     = (bus.id_rs1_used_ip && slot_match(ex_q, rs1)) ||
                   (bus.id_rs2_used_ip && slot_match(ex_q, rs2));
      load_use_c = !reset && bus.id_valid_ip && ex_q.is_load && ld_hit && !flush_c;

      state_d = state_q;
      fcnt_d  = fcnt_q;
      case (state_q)
         RUN, LOAD_STALL: begin
            if (redirect_c) begin
               if (FLUSH_DEPTH > 1) begin
                  state_d = FLUSH;
                  fcnt_d  = FC_W'(FLUSH_DEPTH - 1);
               end else begin
                  state_d = RUN;
               end
            end else if (load_use_c) begin
               state_d = LOAD_STALL;
            end else begin
               state_d = RUN;
            end
         end
         FLUSH: begin
            if (fcnt_q <= FC_W'(1)) begin
               state_d = RUN;
               fcnt_d  = '0;
            end else begin
               fcnt_d = fcnt_q - FC_W'(1);
            end
         end
         default: begin
            state_d = RUN;
            fcnt_d  = '0;
         end
      endcase

      // Stalled or squashed decode enters EX as a bubble with register operands.
      ex_d = '0;
      fa_d = FWD_REG;
      fb_d = FWD_REG;
      if (bus.id_valid_ip && !load_use_c && !flush_c) begin
         ex_d.valid     = 1'b1;
         ex_d.rd        = RD_MAX_W'(rd_a);
         ex_d.reg_write = bus.id_reg_write_ip;
         ex_d.is_load   = bus.id_is_load_ip;
         fa_d           = fwd_sel(bus.id_rs1_used_ip, rs1, ex_q, mem_q);
         fb_d           = fwd_sel(bus.id_rs2_used_ip, rs2, ex_q, mem_q);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= RUN;
         fcnt_q  <= '0;
         ex_q    <= '0;
         mem_q   <= '0;
         fa_q    <= FWD_REG;
         fb_q    <= FWD_REG;
      end else begin
         state_q <= state_d;
         fcnt_q  <= fcnt_d;
         ex_q    <= ex_d;
         mem_q   <= ex_q;
         fa_q    <= fa_d;
         fb_q    <= fb_d;
      end
   end

   hazard_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clock (clock),
      .reset (reset),
      .inc   (load_use_c),
      .count (stall_cnt)
   );

   hazard_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clock (clock),
      .reset (reset),
      .inc   (redirect_c),
      .count (flush_cnt)
   );

   assign bus.fa_mux_op      = fa_q;
   assign bus.fb_mux_op      = fb_q;
   assign bus.stall_if_op    = load_use_c;
   assign bus.stall_id_op    = load_use_c;
   assign bus.bubble_ex_op   = load_use_c || redirect_c;
   assign bus.flush_if_op    = flush_c;
   assign bus.flush_id_op    = flush_c;
   assign bus.stall_count_op = stall_cnt;
   assign bus.flush_count_op = flush_cnt;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
// Directed bench for hazard_forward_ctrl: vector table plus multi-cycle sequences.
module tb_hazard_forward_ctrl;
   import hazard_forward_ctrl_pkg::*;

   localparam int unsigned CNT_W = 2;
   localparam int unsigned NVEC  = 18;

   typedef struct {
      logic       v;
      logic [4:0] rs1;
      logic       u1;
      logic [4:0] rs2;
      logic       u2;
      logic [4:0] rd;
      logic       wr;
      logic       ld;
   } instr_t;

   typedef struct {
      instr_t            ins;
      logic              redir;
      forward_mux_code_e fa;
      forward_mux_code_e fb;
      logic              stall;
      logic              bub;
      logic              flush;
   } vec_t;

   logic clock = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;
   vec_t vt [NVEC];

   hazard_forward_ctrl_if #(.REG_ADDR_W(5), .CNT_W(CNT_W)) bus ();

   hazard_forward_ctrl #(.REG_ADDR_W(5), .FLUSH_DEPTH(2), .CNT_W(CNT_W)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   function automatic instr_t alu(logic [4:0] rd, logic [4:0] rs1, logic [4:0] rs2);
      instr_t i = '{1'b1, rs1, 1'b1, rs2, 1'b1, rd, 1'b1, 1'b0};
      return i;
   endfunction

   function automatic instr_t lw(logic [4:0] rd, logic [4:0] rs1);
      instr_t i = '{1'b1, rs1, 1'b1, 5'd0, 1'b0, rd, 1'b1, 1'b1};
      return i;
   endfunction

   function automatic instr_t nop();
      instr_t i = '{1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0};
      return i;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
      end
   endtask

   task automatic chk_ctl(input string tag, input logic st, input logic bub, input logic fl);
      chk({tag, "_stall_if"}, 32'(bus.stall_if_op), 32'(st));
      chk({tag, "_stall_id"}, 32'(bus.stall_id_op), 32'(st));
      chk({tag, "_bubble"},   32'(bus.bubble_ex_op), 32'(bub));
      chk({tag, "_flush_if"}, 32'(bus.flush_if_op), 32'(fl));
      chk({tag, "_flush_id"}, 32'(bus.flush_id_op), 32'(fl));
   endtask

   task automatic chk_fwd(input string tag, input forward_mux_code_e fa, input forward_mux_code_e fb);
      chk({tag, "_fa"}, 32'(bus.fa_mux_op), 32'(fa));
      chk({tag, "_fb"}, 32'(bus.fb_mux_op), 32'(fb));
   endtask

   task automatic chk_cnt(input string tag, input int sc, input int fc);
      chk({tag, "_stall_cnt"}, 32'(bus.stall_count_op), 32'(sc));
      chk({tag, "_flush_cnt"}, 32'(bus.flush_count_op), 32'(fc));
   endtask

   task automatic apply(input instr_t i, input logic r);
      bus.id_valid_ip     = i.v;
      bus.id_rs1_addr_ip  = i.rs1;
      bus.id_rs1_used_ip  = i.u1;
      bus.id_rs2_addr_ip  = i.rs2;
      bus.id_rs2_used_ip  = i.u2;
      bus.id_rd_addr_ip   = i.rd;
      bus.id_reg_write_ip = i.wr;
      bus.id_is_load_ip   = i.ld;
      bus.ex_redirect_ip  = r;
   endtask

   // Present one decode cycle on the falling edge, settle, then let the caller sample.
   task automatic cyc(input instr_t i, input logic r);
      @(negedge clock);
      apply(i, r);
      #1;
   endtask

   initial begin
      // Back-to-back ALU dependency, ALU->nop->consumer, x0 producer, load-use, EX-over-MEM priority
      vt[0]  = '{alu(5'd5, 5'd1, 5'd2), 1'b0, FWD_REG, FWD_REG, 1'b0, 1'b0, 1'b0};
      vt[1]  = '{alu(5'd6, 5'd5, 5'd1), 1'b0, FWD_REG, FWD_REG, 1'b0, 1'b0, 1'b0};
      vt[2]  = '{nop(),                 1'b0, FWD_ALU, FWD_REG, 1'b0, 1'b0, 1'b0};
      vt[3]  = '{alu(5'd5, 5'd1, 5'd2), 1'b0, FWD_REG, FWD_REG, 1'b0, 1'b0, 1'b0};
      vt[4]  = '{nop(),                 1'b0, FWD_REG, FWD_REG, 1'b0, 1'b0, 1'b0};
      vt[5]  = '{alu(5'd7, 5'd1, 5'd5), 1'b0, FWD_REG, FWD_REG, 1'b0, 1'b0, 1'b0};
      vt[6]  = '{nop(),                 1'b0, FWD_REG, FWD_WB,  1'b0, 1'b0, 1'b0};
      vt[7]  = '{alu(5'd0, 5'd1, 5'd2), 1'b0, FWD_REG, FWD_REG, 1'b0, 1'b0, 1'b0};
      vt[8]  = '{alu(5'd9, 5'd0, 5'd0), 1'b0, FWD_REG, FWD_REG, 1'b0, 1'b0, 1'b0};
      vt[9]  = '{nop(),                 1'b0, FWD_REG, FWD_REG, 1'b0, 1'b0, 1'b0};
      vt[10] = '{lw(5'd5, 5'd2),        1'b0, FWD_REG, FWD_REG, 1'b0, 1'b0, 1'b0};
      vt[11] = '{alu(5'd6, 5'd5, 5'd5), 1'b0, FWD_REG, FWD_REG, 1'b1, 1'b1, 1'b0};
      vt[12] = '{alu(5'd6, 5'd5, 5'd5), 1'b0, FWD_REG, FWD_REG, 1'b0, 1'b0, 1'b0};
      vt[13] = '{nop(),                 1'b0, FWD_WB,  FWD_WB,  1'b0, 1'b0, 1'b0};
      vt[14] = '{alu(5'd5, 5'd1, 5'd2), 1'b0, FWD_REG, FWD_REG, 1'b0, 1'b0, 1'b0};
      vt[15] = '{alu(5'd5, 5'd3, 5'd4), 1'b0, FWD_REG, FWD_REG, 1'b0, 1'b0, 1'b0};
      vt[16] = '{alu(5'd8, 5'd5, 5'd5), 1'b0, FWD_REG, FWD_REG, 1'b0, 1'b0, 1'b0};
      vt[17] = '{nop(),                 1'b0, FWD_ALU, FWD_ALU, 1'b0, 1'b0, 1'b0};

      apply(nop(), 1'b0);
      reset = 1'b1;
      repeat (3) @(negedge clock);
      #1;
      chk_fwd("in_reset", FWD_REG, FWD_REG);
      chk_ctl("in_reset", 1'b0, 1'b0, 1'b0);
      chk_cnt("in_reset", 0, 0);
      reset = 1'b0;

      for (int k = 0; k < int'(NVEC); k++) begin
         cyc(vt[k].ins, vt[k].redir);
         chk_fwd($sformatf("vec%0d", k), vt[k].fa, vt[k].fb);
         chk_ctl($sformatf("vec%0d", k), vt[k].stall, vt[k].bub, vt[k].flush);
      end
      chk_cnt("after_table", 1, 0);

      // Redirect pulse held into the flush window: second assertion is ignored.
      cyc(nop(), 1'b1);
      chk_ctl("redir_c0", 1'b0, 1'b1, 1'b1);
      cyc(nop(), 1'b1);
      chk_ctl("redir_c1", 1'b0, 1'b0, 1'b1);
      cyc(nop(), 1'b0);
      chk_ctl("redir_c2", 1'b0, 1'b0, 1'b0);
      chk_cnt("redir_done", 1, 1);

      // Redirect coincident with a load-use hazard: flush wins, no stall counted.
      cyc(lw(5'd5, 5'd2), 1'b0);
      chk_ctl("coinc_lw", 1'b0, 1'b0, 1'b0);
      cyc(alu(5'd6, 5'd5, 5'd5), 1'b1);
      chk_ctl("coinc_c0", 1'b0, 1'b1, 1'b1);
      cyc(nop(), 1'b0);
      chk_ctl("coinc_c1", 1'b0, 1'b0, 1'b1);
      cyc(nop(), 1'b0);
      chk_ctl("coinc_c2", 1'b0, 1'b0, 1'b0);
      chk_cnt("coinc_done", 1, 2);

      // Drive both counters past all-ones.
      for (int k = 0; k < 3; k++) begin
         cyc(lw(5'd5, 5'd2), 1'b0);
         cyc(alu(5'd6, 5'd5, 5'd5), 1'b0);
         chk_ctl($sformatf("sat_stall%0d", k), 1'b1, 1'b1, 1'b0);
         cyc(alu(5'd6, 5'd5, 5'd5), 1'b0);
      end
      cyc(nop(), 1'b0);
      chk_fwd("sat_replay", FWD_WB, FWD_WB);
      for (int k = 0; k < 2; k++) begin
         cyc(nop(), 1'b1);
         cyc(nop(), 1'b0);
         cyc(nop(), 1'b0);
      end
      chk_cnt("saturated", 3, 3);

      // Asynchronous reset in the middle of a load-use stall.
      cyc(lw(5'd5, 5'd2), 1'b0);
      cyc(alu(5'd6, 5'd5, 5'd5), 1'b0);
      chk_ctl("pre_rst_stall", 1'b1, 1'b1, 1'b0);
      reset = 1'b1;
      #1;
      chk_ctl("rst_stall", 1'b0, 1'b0, 1'b0);
      chk_fwd("rst_stall", FWD_REG, FWD_REG);
      chk_cnt("rst_stall", 0, 0);
      @(negedge clock);
      reset = 1'b0;

      // Asynchronous reset in the middle of a flush window.
      cyc(nop(), 1'b1);
      cyc(nop(), 1'b0);
      chk_ctl("pre_rst_flush", 1'b0, 1'b0, 1'b1);
      chk_cnt("pre_rst_flush", 0, 1);
      reset = 1'b1;
      #1;
      chk_ctl("rst_flush", 1'b0, 1'b0, 1'b0);
      chk_fwd("rst_flush", FWD_REG, FWD_REG);
      chk_cnt("rst_flush", 0, 0);
      @(negedge clock);
      reset = 1'b0;
      cyc(nop(), 1'b0);
      chk_ctl("post_rst", 1'b0, 1'b0, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
